game_match_builder: RTL and testbench

- Builds the 25-bit cross and self match matrices consumed by the feedback logic, from serially loaded letters.
- A 5-letter secret is loaded and stored. Each 5-letter guess is then streamed in, and the matrices are filled in incrementally as its letters arrive.
- It sits between the keyboard/letter-entry path and the feedback block. It holds the finished matrices until they are acknowledged.

---
 rtl/game_match_builder.sv | 182 ++++++++++++++++++
 tb/tb_game_match_builder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_match_builder.sv
// Collects a serially entered secret and guess, and builds the guess-vs-secret
// (cross) and guess-vs-guess (self) letter match matrices for the feedback stage.
module game_match_builder #(
  parameter int unsigned LETTER_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LETTER_W-1:0] in_letter,
  input  logic                in_is_secret,
  output logic                secret_loaded,
  output logic                err,
  output logic                out_valid,
  input  logic                out_ack,
  output logic [24:0]         cross_match_matrix,
  output logic [24:0]         self_match_matrix
);

  localparam int unsigned N     = 5;
  localparam int unsigned MAT_W = N * N;
  localparam int unsigned POS_W = 3;

  typedef enum logic [1:0] {IDLE, LOAD_SEC, LOAD_GUESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [LETTER_W-1:0] secret_q [N];
  logic [LETTER_W-1:0] secret_d [N];
  logic [LETTER_W-1:0] guess_q  [N];
  logic [LETTER_W-1:0] guess_d  [N];
  logic                secret_loaded_q, secret_loaded_d;
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [MAT_W-1:0]    cross_q, cross_d;
  logic [MAT_W-1:0]    self_q, self_d;

  logic                xfer;
  logic                start_sec, cont_sec, start_guess, cont_guess, drop;
  logic [POS_W-1:0]    gk;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d         = state_q;
    pos_d           = pos_q;
    secret_d        = secret_q;
    guess_d         = guess_q;
    secret_loaded_d = secret_loaded_q;
    err_d           = 1'b0;
    cross_d         = cross_q;
    self_d          = self_q;
    start_sec       = 1'b0;
    cont_sec        = 1'b0;
    start_guess     = 1'b0;
    cont_guess      = 1'b0;
    drop            = 1'b0;
    gk              = '0;
    xfer            = in_valid && in_ready_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (in_is_secret)         start_sec   = 1'b1;
          else if (secret_loaded_q) start_guess = 1'b1;
          else                      drop        = 1'b1;
        end
      end
      LOAD_SEC: begin
        if (xfer) begin
          if (in_is_secret) cont_sec = 1'b1;
          else              drop     = 1'b1;
        end
      end
      LOAD_GUESS: begin
        if (xfer) begin
          if (in_is_secret) start_sec  = 1'b1;
          else              cont_guess = 1'b1;
        end
      end
      DONE: begin
        if (out_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An aborted guess leaves cleared matrices behind
    if (start_sec) begin
      if (state_q == LOAD_GUESS) begin
        cross_d = '0;
        self_d  = '0;
      end
      secret_d[0]     = in_letter;
      secret_loaded_d = 1'b0;
      pos_d           = POS_W'(1);
      state_d         = LOAD_SEC;
    end

    if (cont_sec) begin
      secret_d[pos_q] = in_letter;
      if (pos_q == POS_W'(N - 1)) begin
        secret_loaded_d = 1'b1;
        pos_d           = '0;
        state_d         = IDLE;
      end else begin
        pos_d = pos_q + POS_W'(1);
      end
    end

    if (drop) begin
      err_d   = 1'b1;
      pos_d   = '0;
      state_d = IDLE;
    end

    // Fill row gk of both matrices plus the mirrored self column
    if (start_guess || cont_guess) begin
      gk = start_guess ? '0 : pos_q;
      if (start_guess) begin
        cross_d = '0;
        self_d  = '0;
      end
      guess_d[gk] = in_letter;
      for (int unsigned j = 0; j < N; j++) begin
        if (secret_q[POS_W'(j)] == in_letter) cross_d[5'(N * gk + j)] = 1'b1;
        if ((POS_W'(j) < gk) && (guess_q[POS_W'(j)] == in_letter)) begin
          self_d[5'(N * gk + j)] = 1'b1;
          self_d[5'(N * j + gk)] = 1'b1;
        end
      end
      self_d[5'(N * gk + gk)] = 1'b1;
      if (gk == POS_W'(N - 1)) begin
        pos_d   = '0;
        state_d = DONE;
      end else begin
        pos_d   = gk + POS_W'(1);
        state_d = LOAD_GUESS;
      end
    end

    in_ready_d  = (state_d != DONE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      pos_q           <= '0;
      secret_loaded_q <= 1'b0;
      err_q           <= 1'b0;
      out_valid_q     <= 1'b0;
      in_ready_q      <= 1'b1;
      cross_q         <= '0;
      self_q          <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        secret_q[i] <= '0;
        guess_q[i]  <= '0;
      end
    end else begin
      state_q         <= state_d;
      pos_q           <= pos_d;
      secret_loaded_q <= secret_loaded_d;
      err_q           <= err_d;
      out_valid_q     <= out_valid_d;
      in_ready_q      <= in_ready_d;
      cross_q         <= cross_d;
      self_q          <= self_d;
      for (int unsigned i = 0; i < N; i++) begin
        secret_q[i] <= secret_d[i];
        guess_q[i]  <= guess_d[i];
      end
    end
  end

  assign in_ready           = in_ready_q;
  assign secret_loaded      = secret_loaded_q;
  assign err                = err_q;
  assign out_valid          = out_valid_q;
  assign cross_match_matrix = cross_q;
  assign self_match_matrix  = self_q;

endmodule

// File: tb/tb_game_match_builder.sv
// Randomized and directed bench for game_match_builder against a word-level
// reference model that derives the matrices from complete words.
module tb_game_match_builder;

  localparam int unsigned LW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_letter;
  logic          in_is_secret;
  logic          secret_loaded;
  logic          err;
  logic          out_valid;
  logic          out_ack;
  logic [24:0]   cross_m;
  logic [24:0]   self_m;

  always #5 clk = ~clk;

  game_match_builder #(.LETTER_W(LW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_letter          (in_letter),
    .in_is_secret       (in_is_secret),
    .secret_loaded      (secret_loaded),
    .err                (err),
    .out_valid          (out_valid),
    .out_ack            (out_ack),
    .cross_match_matrix (cross_m),
    .self_match_matrix  (self_m)
  );

  int n_vec = 0;
  int n_err = 0;
  bit auto_ack = 1'b0;
  int vcyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: words are collected whole; matrices computed on completion
  logic [LW-1:0] m_sec [5];
  logic [LW-1:0] wbuf  [5];
  int            wlen;
  bit            wsec;
  bit            m_sec_ok, m_done, m_err, m_mat_def;
  logic [24:0]   m_cross, m_self;

  always @(posedge clk or negedge rst_n) begin
    bit take;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) m_sec[i] = '0;
      wlen = 0; wsec = 1'b0;
      m_sec_ok = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_mat_def = 1'b1; m_cross = '0; m_self = '0;
    end else begin
      m_err = 1'b0;
      take  = 1'b0;
      if (m_done) begin
        if (out_ack) m_done = 1'b0;
      end else if (in_valid) begin
        if (wlen > 0 && wsec != in_is_secret) begin
          if (!wsec) begin
            m_cross = '0; m_self = '0; m_mat_def = 1'b1;
          end
          wlen = 0;
        end
        if (wlen == 0) begin
          if (in_is_secret) begin
            m_sec_ok = 1'b0; wsec = 1'b1; take = 1'b1;
          end else if (!m_sec_ok) begin
            m_err = 1'b1;
          end else begin
            wsec = 1'b0; take = 1'b1; m_mat_def = 1'b0;
          end
        end else begin
          take = 1'b1;
        end
        if (take) begin
          wbuf[wlen] = in_letter;
          wlen++;
          if (wlen == 5) begin
            wlen = 0;
            if (wsec) begin
              for (int i = 0; i < 5; i++) m_sec[i] = wbuf[i];
              m_sec_ok = 1'b1;
            end else begin
              for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) begin
                  m_cross[5*i+j] = (wbuf[i] == m_sec[j]);
                  m_self[5*i+j]  = (wbuf[i] == wbuf[j]);
                end
              m_done = 1'b1; m_mat_def = 1'b1;
            end
          end
        end
      end
    end
  end

  always @(posedge clk) if (in_valid) vcyc++;

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(!m_done));
    check("out_valid", 32'(out_valid), 32'(m_done));
    check("secret_loaded", 32'(secret_loaded), 32'(m_sec_ok));
    check("err", 32'(err), 32'(m_err));
    if (m_mat_def) begin
      check("cross", 32'(cross_m), 32'(m_cross));
      check("self", 32'(self_m), 32'(m_self));
    end
  end

  task automatic put(input bit sec, input logic [LW-1:0] l);
    bit acc;
    @(negedge clk);
    in_valid = 1'b1; in_is_secret = sec; in_letter = l;
    for (int t = 0; ; t++) begin
      acc = !m_done;
      out_ack = (auto_ack && m_done) ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(posedge clk);
      if (acc) break;
      if (t >= 50) begin
        check("accept_timeout", 32'(t), 32'd0);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ack  = (auto_ack && m_done) ? ($urandom_range(0, 1) == 0) : 1'b0;
    end
  endtask

  logic [LW-1:0] crane [5];
  logic [LW-1:0] eerie [5];

  initial begin
    crane = '{5'd3, 5'd18, 5'd1, 5'd14, 5'd5};
    eerie = '{5'd5, 5'd5, 5'd18, 5'd9, 5'd5};
    rst_n = 1'b0; in_valid = 1'b0; in_is_secret = 1'b0; in_letter = '0; out_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_cross", 32'(cross_m), 32'd0);

    // Guess without secret is dropped with a one-cycle err
    put(1'b0, 5'd3);
    @(negedge clk) in_valid = 1'b0;
    check("err_pulse", 32'(err), 32'd1);
    @(negedge clk);
    check("err_clear", 32'(err), 32'd0);
    check("no_secret", 32'(secret_loaded), 32'd0);

    for (int i = 0; i < 5; i++) put(1'b1, crane[i]);
    for (int i = 0; i < 5; i++) put(1'b0, crane[i]);
    @(negedge clk) in_valid = 1'b0;
    check("crane_valid", 32'(out_valid), 32'd1);
    check("crane_cross", 32'(cross_m), 32'h1041041);
    check("crane_self", 32'(self_m), 32'h1041041);
    repeat (10) begin
      @(negedge clk);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_cross", 32'(cross_m), 32'h1041041);
    end
    out_ack = 1'b1;
    @(negedge clk) out_ack = 1'b0;
    check("ack_valid", 32'(out_valid), 32'd0);
    check("ack_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 5; i++) put(1'b0, eerie[i]);
    @(negedge clk) in_valid = 1'b0;
    check("eerie_cross", 32'(cross_m), 32'h1000A10);
    check("eerie_self", 32'(self_m), 32'h1341273);
    out_ack = 1'b1;
    @(negedge clk) out_ack = 1'b0;

    // Guess aborted by a secret letter
    put(1'b0, 5'd5); put(1'b0, 5'd5); put(1'b1, 5'd1);
    @(negedge clk) in_valid = 1'b0;
    check("abort_cross", 32'(cross_m), 32'd0);
    check("abort_self", 32'(self_m), 32'd0);
    check("abort_sl", 32'(secret_loaded), 32'd0);
    for (int i = 1; i <= 4; i++) put(1'b1, LW'(i));
    @(negedge clk) in_valid = 1'b0;
    check("reload_sl", 32'(secret_loaded), 32'd1);

    // Asynchronous reset in the middle of a guess
    put(1'b0, 5'd1); put(1'b0, 5'd2); put(1'b0, 5'd3);
    @(negedge clk) in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_sl", 32'(secret_loaded), 32'd0);
    check("arst_self", 32'(self_m), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Back-to-back transfers with in_valid held high
    @(negedge clk) vcyc = 0;
    put(1'b1, 5'd7); put(1'b1, 5'd8); put(1'b1, 5'd9); put(1'b1, 5'd7); put(1'b1, 5'd8);
    put(1'b0, 5'd8); put(1'b0, 5'd7); put(1'b0, 5'd7); put(1'b0, 5'd1); put(1'b0, 5'd8);
    @(negedge clk) in_valid = 1'b0;
    check("b2b_cycles", 32'(vcyc), 32'd10);
    check("b2b_valid", 32'(out_valid), 32'd1);

    auto_ack = 1'b1;
    for (int w = 0; w < 150; w++) begin
      int r, len;
      bit k;
      r = $urandom_range(0, 9);
      k = (r < 3);
      len = (r < 8) ? 5 : $urandom_range(1, 4);
      if (r >= 8) k = $urandom_range(0, 1);
      for (int i = 0; i < len; i++) put(k, LW'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
